// File: rtl/lane_queue_dispatch.sv
// rtl/lane_queue_dispatch.sv - per-lane waiting-car queue and animator dispatch FSM
module lane_queue_dispatch #(
    parameter int CNT_W      = 4,
    parameter int MAX_CARS   = 15,
    parameter int GAP_CYCLES = 4
) (
    input  logic             traffic_clk,
    input  logic             reset_n,
    input  logic             car_btn,
    input  logic             go,
    input  logic             decrement_car,
    output logic             add_car,
    output logic [CNT_W-1:0] car_count,
    output logic             queue_empty,
    output logic             queue_full,
    output logic             car_dropped
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CARS);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t             ps_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               add_car_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               btn_q;
    logic               dropped_q, dropped_d;

    logic               arrive;
    logic               full;
    logic               empty;

    assign arrive = car_btn & ~btn_q;
    assign full   = (count_q == MAX_CNT);
    assign empty  = (count_q == '0);

    // Simultaneous arrival and retirement cancel out, so neither is lost
    // even at the full or empty boundary.
    always_comb begin
        count_d   = count_q;
        dropped_d = 1'b0;
        if (arrive && !decrement_car) begin
            if (full) begin
                dropped_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (decrement_car && !arrive && !empty) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge traffic_clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            btn_q     <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            btn_q     <= car_btn;
            dropped_q <= dropped_d;
        end
    end

    // Decrements are applied by the counter in every state; the FSM only
    // uses them to leave REQUEST, so a late pulse after go drops still lands.
    always_ff @(posedge traffic_clk) begin
        if (!reset_n) begin
            ps_q      <= IDLE;
            gap_cnt_q <= '0;
            add_car_q <= 1'b0;
        end else begin
            case (ps_q)
                IDLE: begin
                    if (go && !empty) begin
                        ps_q      <= REQUEST;
                        add_car_q <= 1'b1;
                    end else begin
                        add_car_q <= 1'b0;
                    end
                end
                REQUEST: begin
                    if (decrement_car) begin
                        ps_q      <= GAP;
                        gap_cnt_q <= GAP_LOAD;
                        add_car_q <= 1'b0;
                    end else if (!go) begin
                        ps_q      <= IDLE;
                        add_car_q <= 1'b0;
                    end else begin
                        add_car_q <= 1'b1;
                    end
                end
                GAP: begin
                    add_car_q <= 1'b0;
                    if (gap_cnt_q == '0) begin
                        ps_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    ps_q      <= IDLE;
                    add_car_q <= 1'b0;
                end
            endcase
        end
    end

    assign add_car     = add_car_q;
    assign car_count   = count_q;
    assign car_dropped = dropped_q;
    assign queue_empty = empty;
    assign queue_full  = full;

endmodule
